gcd_engine: RTL and testbench

Subtractive greatest-common-divisor engine with a start/done handshake.
- Latches two unsigned operands and iterates by subtracting the smaller from the larger until they are equal or one is zero.
- Presents the result with a one-cycle done pulse.
- Sits directly upstream of the result consumer, which uses an equality comparator against a constant.
- Controller and datapath live in one block; the equality and zero detection it performs internally uses the same compare-to-value idiom as the rest of the datapath.

---
 rtl/gcd_pkg.sv | 9 +
 rtl/gcd_datapath.sv | 54 +++++
 rtl/gcd_engine.sv | 107 ++++++++++
 tb/tb_gcd_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared constants for the subtractive GCD engine: FSM state encoding and default width.
// Imported by the datapath and the top-level controller.
package gcd_pkg;
    localparam int GCD_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/gcd_datapath.sv
// Operand registers A/B with subtractors, unsigned magnitude compare and zero/equal flags.
// One register update per cycle under load/sub_a/sub_b; flags are combinational from the registers.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sub_a,
    input  logic             sub_b,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] b_val,
    output logic             a_zero,
    output logic             b_zero,
    output logic             a_eq_b,
    output logic             a_gt_b
);
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // The controller only asserts a subtract strobe toward the larger operand, so no underflow.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = a_in;
            b_d = b_in;
        end else begin
            if (sub_a) a_d = a_q - b_q;
            if (sub_b) b_d = b_q - a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_val  = a_q;
    assign b_val  = b_q;
    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);
    assign a_eq_b = (a_q == b_q);
    assign a_gt_b = (a_q > b_q);
endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine, start/done handshake; done arrives S+2 cycles after start (S = subtracts).
// No backpressure: start is taken only while ready, ignored otherwise. GCD_ITER_COUNT_EN adds iter_count.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_count
`endif
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, sub_a, sub_b;
    logic [WIDTH-1:0] a_val, b_val;
    logic             a_zero, b_zero, a_eq_b, a_gt_b;

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .sub_a  (sub_a),
        .sub_b  (sub_b),
        .a_in   (a_in),
        .b_in   (b_in),
        .a_val  (a_val),
        .b_val  (b_val),
        .a_zero (a_zero),
        .b_zero (b_zero),
        .a_eq_b (a_eq_b),
        .a_gt_b (a_gt_b)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        sub_a    = 1'b0;
        sub_b    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Termination checks take priority over subtraction, zero operands first.
                if (a_zero) begin
                    result_d = b_val;
                    state_d  = DONE;
                end else if (b_zero || a_eq_b) begin
                    result_d = a_val;
                    state_d  = DONE;
                end else if (a_gt_b) begin
                    sub_a = 1'b1;
                end else begin
                    sub_b = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_q, iter_d;

    always_comb begin
        iter_d = iter_q;
        if (load)
            iter_d = '0;
        else if ((sub_a || sub_b) && (iter_q != '1))
            iter_d = iter_q + WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) iter_q <= '0;
        else     iter_q <= iter_d;
    end

    assign iter_count = iter_q;
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: accepted starts push Euclid-model expectations, done pops them.
module tb_gcd_engine;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ready, done;
    logic [W-1:0] result;
`ifdef GCD_ITER_COUNT_EN
    logic [W-1:0] iter_count;
`endif

    gcd_engine #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .ready  (ready),
        .done   (done),
        .result (result)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int cyc;
        int subs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_result = 0;
    logic prev_done = 1'b0;
    exp_t e;
    int   g, s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Euclid by division; the subtractive walk performs sum(quotients)-1 subtractions.
    function automatic void ref_gcd(input int a, input int b, output int gv, output int sv);
        int x, y, r, sum;
        if (a == 0) begin
            gv = b; sv = 0;
        end else if (b == 0) begin
            gv = a; sv = 0;
        end else begin
            x = (a > b) ? a : b;
            y = (a > b) ? b : a;
            sum = 0;
            while (y != 0) begin
                sum += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            gv = x;
            sv = sum - 1;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            last_result = 0;
            prev_done   = 1'b0;
        end else begin
            chk("ready_idle_only", int'(ready), int'(q.size() == 0));
            chk("ready_done_exclusive", int'(ready & done), 0);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    e = q.pop_front();
                    chk("result", int'(result), e.res);
                    chk("done_latency", cyc, e.cyc);
`ifdef GCD_ITER_COUNT_EN
                    chk("iter_count", int'(iter_count), (e.subs > 255) ? 255 : e.subs);
`endif
                end
                chk("done_one_cycle", int'(prev_done), 0);
                last_result = int'(result);
            end else begin
                chk("result_hold", int'(result), last_result);
            end
            prev_done = done;
            if (ready && start) begin
                ref_gcd(int'(a_in), int'(b_in), g, s);
                q.push_back('{res: g, cyc: cyc + s + 2, subs: s});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", int'(ready), 1);
    endtask

    task automatic run_op(input int a, input int b);
        wait_ready();
        start = 1'b1;
        a_in  = W'(a);
        b_in  = W'(b);
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
    endtask

    initial begin
        int ra, rb, n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(12, 8);
        run_op(0, 5);
        run_op(0, 0);
        run_op(9, 0);

        // Start held high across a whole operation: second pair waits for IDLE.
        wait_ready();
        start = 1'b1;
        a_in = 8'd21;
        b_in = 8'd6;
        @(posedge clk); #1;
        a_in = 8'd17;
        b_in = 8'd17;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_start_ready", int'(ready), 1);
        @(posedge clk); #1;
        start = 1'b0;

        run_op(255, 1);
        run_op(1, 255);

        // Abort mid-calculation; previous result is nonzero so the clear is visible.
        run_op(200, 1);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op(ra, rb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
